// File: rtl/seq_mult_if.sv
// Start/done handshake bundle for the sequential multiplier.
// The requester drives the operands and start; the multiplier returns
// busy/done, the 2M-bit product and the ALU flags.
interface seq_mult_if #(
  parameter int M = 4
);
  logic           start;
  logic           sgn;
  logic [M-1:0]   A;
  logic [M-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*M-1:0] R;
  logic           C;
  logic           N;
  logic           V;
  logic           Z;

  modport master (
    output start, sgn, A, B,
    input  busy, done, R, C, N, V, Z
  );

  modport slave (
    input  start, sgn, A, B,
    output busy, done, R, C, N, V, Z
  );
endinterface

// File: rtl/seq_mult.sv
// Sequential radix-2 shift-add multiplier, M x M -> 2M bits in M cycles.
// Signed mode uses sign-corrected shift-add: the multiplicand is sign
// extended to 2M bits and the partial product of the multiplier MSB is
// subtracted instead of added (its weight is -2^(M-1)). All arithmetic
// is modulo 2^(2M), which is exact because every product fits in 2M bits.
module seq_mult #(
  parameter int M = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_mult_if.slave  bus
);

  localparam int W  = 2 * M;
  localparam int CW = (M > 2) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched operation and running datapath state
  logic                sgn_p0;
  logic [CW-1:0]       cnt_p0;
  logic signed [W-1:0] acc_p0;
  logic signed [W-1:0] mcand_p0;
  logic [M-1:0]        mplr_p0;

  // Registered results, only updated on the DONE-entry edge
  logic [W-1:0]        r_q;
  logic                c_q;
  logic                n_q;
  logic                v_q;
  logic                z_q;

  logic signed [W-1:0] a_ext;
  logic signed [W-1:0] addend;
  logic signed [W-1:0] acc_nxt;
  logic                last;
  logic [3:0]          flags_nxt;

  // Flags for the ALU flag register: {C, N, V, Z}.
  // Signed overflow means the top M+1 bits are not a pure sign extension.
  function automatic logic [3:0] flags_of(input logic s, input logic [W-1:0] r);
    logic       c;
    logic       n;
    logic       v;
    logic       z;
    logic [M:0] top;
    top = r[W-1:M-1];
    c   = ~s & (|r[W-1:M]);
    n   = s & r[W-1];
    v   = s ? ~((&top) | ~(|top)) : c;
    z   = ~(|r);
    return {c, n, v, z};
  endfunction

  // Step arithmetic: add (or, for the signed MSB step, subtract) the shifted multiplicand
  always_comb begin
    a_ext     = {{M{bus.sgn & bus.A[M-1]}}, bus.A};
    last      = (cnt_p0 == CW'(M - 1));
    addend    = mplr_p0[0] ? mcand_p0 : '0;
    acc_nxt   = (sgn_p0 && last) ? (acc_p0 - addend) : (acc_p0 + addend);
    flags_nxt = flags_of(sgn_p0, acc_nxt);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only honoured in IDLE, DONE always lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand latch at start, then one partial-product step per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_p0   <= 1'b0;
      cnt_p0   <= '0;
      acc_p0   <= '0;
      mcand_p0 <= '0;
      mplr_p0  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sgn_p0   <= bus.sgn;
            cnt_p0   <= '0;
            acc_p0   <= '0;
            mcand_p0 <= a_ext;
            mplr_p0  <= bus.B;
          end
        end
        RUN: begin
          acc_p0   <= acc_nxt;
          mcand_p0 <= mcand_p0 <<< 1;
          mplr_p0  <= mplr_p0 >> 1;
          cnt_p0   <= cnt_p0 + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result stage: capture product and flags on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      c_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else if (state == RUN && last) begin
      r_q <= acc_nxt;
      {c_q, n_q, v_q, z_q} <= flags_nxt;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.R    = r_q;
  assign bus.C    = c_q;
  assign bus.N    = n_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: directed M=4 vectors and corner sequences, then
// 1000 back-to-back randomized M=8 operations against a reference model.
module tb_seq_mult;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seq_mult_if #(.M(4)) i4 ();
  seq_mult_if #(.M(8)) i8 ();

  seq_mult #(.M(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  seq_mult #(.M(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] r;
    logic       c;
    logic       n;
    logic       v;
    logic       z;
    bit         pulse;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One M=4 operation; returns latency (negedges after the start edge until done),
  // busy cycles and done pulses seen over a window extending past done.
  task automatic op4(input logic s, input logic [3:0] a, input logic [3:0] b,
                     input bit pulse, output int lat, output int bsy, output int nd);
    lat = 0; bsy = 0; nd = 0;
    @(negedge clk);
    i4.start = 1'b1; i4.sgn = s; i4.A = a; i4.B = b;
    @(posedge clk);
    #1;
    i4.start = 1'b0;
    i4.sgn = ~s; i4.A = 4'($urandom); i4.B = 4'($urandom);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (i4.busy) bsy++;
      if (pulse && k == 2) i4.start = 1'b1;
      if (pulse && k == 3) i4.start = 1'b0;
      if (i4.done) begin
        nd++;
        if (lat == 0) lat = k;
      end
      if (lat != 0 && k >= lat + 3) break;
    end
  endtask

  // Reference: plain integer product and range rules for the flags
  function automatic logic [19:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int          x;
    int          y;
    int          p;
    logic [31:0] pv;
    logic        c;
    logic        n;
    logic        v;
    logic        z;
    x  = s ? int'($signed(a)) : int'(a);
    y  = s ? int'($signed(b)) : int'(b);
    p  = x * y;
    pv = p;
    c  = !s && (p > 255);
    n  = s && (p < 0);
    v  = s ? ((p < -128) || (p > 127)) : (p > 255);
    z  = (p == 0);
    return {pv[15:0], c, n, v, z};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          bsy;
    int          nd;
    logic [9:0]  opq[$];
    logic [9:0]  cur;
    logic [19:0] exp8;
    int          cyc;
    int          lastcyc;
    bit          got;

    total = 0; bad = 0;
    rst_n = 1'b0;
    i4.start = 1'b0; i4.sgn = 1'b0; i4.A = '0; i4.B = '0;
    i8.start = 1'b0; i8.sgn = 1'b0; i8.A = '0; i8.B = '0;

    tv[0] = '{1'b1, 4'h3, 4'hE, 8'hFA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 4'h8, 4'h8, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[2] = '{1'b0, 4'hF, 4'hF, 8'hE1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[3] = '{1'b1, 4'h0, 4'hB, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[4] = '{1'b0, 4'h3, 4'h5, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[5] = '{1'b1, 4'h7, 4'h7, 8'h31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[6] = '{1'b1, 4'h8, 4'h1, 8'hF8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[7] = '{1'b0, 4'h8, 4'h2, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[8] = '{1'b1, 4'h7, 4'h8, 8'hC8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[9] = '{1'b1, 4'hF, 4'hF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst4_busy", i4.busy, 0);
    chk("rst4_done", i4.done, 0);
    chk("rst4_R",    i4.R, 0);
    chk("rst4_flags", {i4.C, i4.N, i4.V, i4.Z}, 0);
    chk("rst8_R",    i8.R, 0);
    chk("rst8_ctl",  {i8.busy, i8.done}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed M=4 vectors
    for (int i = 0; i < 10; i++) begin
      op4(tv[i].s, tv[i].a, tv[i].b, tv[i].pulse, lat, bsy, nd);
      chk($sformatf("v%0d_lat", i),   lat, 5);
      chk($sformatf("v%0d_busy", i),  bsy, 4);
      chk($sformatf("v%0d_ndone", i), nd, 1);
      chk($sformatf("v%0d_R", i),     i4.R, tv[i].r);
      chk($sformatf("v%0d_CNVZ", i),  {i4.C, i4.N, i4.V, i4.Z},
          {tv[i].c, tv[i].n, tv[i].v, tv[i].z});
    end

    // Result hold while idle with changing inputs
    i4.A = 4'h6; i4.B = 4'h6; i4.sgn = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_R", i4.R, 8'h01);

    // Reset in the second RUN cycle aborts the operation
    @(negedge clk);
    i4.start = 1'b1; i4.sgn = 1'b0; i4.A = 4'h9; i4.B = 4'h9;
    @(posedge clk);
    #1 i4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", i4.busy, 0);
    chk("abort_done", i4.done, 0);
    chk("abort_R",    i4.R, 0);
    chk("abort_flags", {i4.C, i4.N, i4.V, i4.Z}, 0);
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (i4.done || i4.busy) nd++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (i4.done || i4.busy) nd++;
    end
    chk("abort_no_done", nd, 0);
    op4(1'b0, 4'h5, 4'h3, 1'b0, lat, bsy, nd);
    chk("after_rst_lat", lat, 5);
    chk("after_rst_R",   i4.R, 8'h0F);

    // M=8 back-to-back with start held high
    cur = {1'b1, 8'h80, 1'b0};
    cur = {1'b1, 8'h80, 1'b0};
    @(negedge clk);
    i8.start = 1'b1;
    cur = 10'b0;
    lastcyc = 0;
    cyc = 0;
    for (int op = 0; op < 1000; op++) begin
      logic s;
      logic [7:0] a;
      logic [7:0] b;
      case (op)
        0: begin s = 1'b1; a = 8'h80; b = 8'h80; end
        1: begin s = 1'b0; a = 8'hFF; b = 8'hFF; end
        2: begin s = 1'b1; a = 8'h80; b = 8'h7F; end
        3: begin s = 1'b0; a = 8'h00; b = 8'hA5; end
        default: begin s = 1'($urandom); a = 8'($urandom); b = 8'($urandom); end
      endcase
      opq.push_back({s, a, 1'b0});
      opq.push_back({1'b0, b, 1'b0});
      i8.sgn = s; i8.A = a; i8.B = b;
      got = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        cyc++;
        if (i8.done) begin
          got = 1'b1;
          break;
        end
        if (i8.busy) begin
          i8.sgn = 1'($urandom); i8.A = 8'($urandom); i8.B = 8'($urandom);
        end
      end
      if (!got) begin
        chk("r8_timeout", 0, 1);
        break;
      end
      cur = opq.pop_front();
      s = cur[9]; a = cur[8:1];
      cur = opq.pop_front();
      b = cur[8:1];
      exp8 = ref8(s, a, b);
      chk($sformatf("r8_op%0d_R", op), i8.R, exp8[19:4]);
      chk($sformatf("r8_op%0d_CNVZ", op), {i8.C, i8.N, i8.V, i8.Z}, exp8[3:0]);
      if (op > 0) chk($sformatf("r8_op%0d_spacing", op), cyc - lastcyc, 10);
      lastcyc = cyc;
    end
    i8.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
